// File: rtl/seg7_display_snoop.sv
// -----------------------------------------------------------------------------
// seg7_display_snoop
//
// Reads back a multiplexed, active-low 7-segment display bus and recovers the
// hex value shown on every digit. The segment and anode lines come from the
// display driver's pins and are asynchronous to clk, so both are passed
// through 2-flop synchronizers.
//
// A digit is captured only once its anode/segment pattern has been stable for
// STABLE_CYCLES synchronized samples. This rejects ghosting while the driver
// switches digits.
//
// When every digit has been captured at least once, the collected nibbles are
// published together with a one-cycle frame_valid_o pulse.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   seg_n_i[6:0]   segment lines, active low, bit0=a .. bit6=g (async)
//   an_n_i[N-1:0]  digit anodes, active low, one-hot when valid (async)
//   err_clr_i      synchronous pulse clearing code_err_o and sel_err_o
//   value_o        recovered nibbles, digit i at [4i+3:4i]
//   blank_mask_o   bit i set = digit i was blank in the last frame
//   frame_valid_o  one-cycle pulse when value_o/blank_mask_o update
//   code_err_o     sticky: an unrecognized non-blank pattern was captured
//   sel_err_o      sticky: a stable multi-hot anode pattern was seen
// -----------------------------------------------------------------------------
module seg7_display_snoop #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n_i,
    input  logic [NUM_DIGITS-1:0]   an_n_i,
    input  logic                    err_clr_i,
    output logic [4*NUM_DIGITS-1:0] value_o,
    output logic [NUM_DIGITS-1:0]   blank_mask_o,
    output logic                    frame_valid_o,
    output logic                    code_err_o,
    output logic                    sel_err_o
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam int SW = NUM_DIGITS + 7;

    localparam logic [CW-1:0]         CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0]         CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]         CNT_PRE  = CW'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1'b1);
    localparam logic [NUM_DIGITS-1:0] AN_ZERO  = NUM_DIGITS'(1'b0);

    // Decode an active-high gfedcba pattern into {known, blank, nibble}.
    // Blank (all segments off) counts as known.
    function automatic logic [5:0] seg_decode(input logic [6:0] pat);
        logic [5:0] res;
        case (pat)
            7'h3F:   res = {1'b1, 1'b0, 4'h0};
            7'h06:   res = {1'b1, 1'b0, 4'h1};
            7'h5B:   res = {1'b1, 1'b0, 4'h2};
            7'h4F:   res = {1'b1, 1'b0, 4'h3};
            7'h66:   res = {1'b1, 1'b0, 4'h4};
            7'h6D:   res = {1'b1, 1'b0, 4'h5};
            7'h7D:   res = {1'b1, 1'b0, 4'h6};
            7'h07:   res = {1'b1, 1'b0, 4'h7};
            7'h7F:   res = {1'b1, 1'b0, 4'h8};
            7'h6F:   res = {1'b1, 1'b0, 4'h9};
            7'h77:   res = {1'b1, 1'b0, 4'hA};
            7'h7C:   res = {1'b1, 1'b0, 4'hB};
            7'h39:   res = {1'b1, 1'b0, 4'hC};
            7'h5E:   res = {1'b1, 1'b0, 4'hD};
            7'h79:   res = {1'b1, 1'b0, 4'hE};
            7'h71:   res = {1'b1, 1'b0, 4'hF};
            7'h00:   res = {1'b1, 1'b1, 4'h0};
            default: res = {1'b0, 1'b0, 4'h0};
        endcase
        return res;
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return (v != AN_ZERO) && ((v & (v - AN_ONE)) == AN_ZERO);
    endfunction

    logic [6:0]                     seg_s1_q, seg_s2_q;
    logic [NUM_DIGITS-1:0]          an_s1_q, an_s2_q;
    logic [SW-1:0]                  prev_q;
    logic [CW-1:0]                  hot_cnt_q, hot_cnt_d;
    logic [CW-1:0]                  multi_cnt_q, multi_cnt_d;
    logic [NUM_DIGITS-1:0]          seen_q, seen_d;
    logic [NUM_DIGITS-1:0][3:0]     dig_nib_q, dig_nib_d;
    logic [NUM_DIGITS-1:0]          dig_blank_q, dig_blank_d;
    logic [4*NUM_DIGITS-1:0]        value_q, value_d;
    logic [NUM_DIGITS-1:0]          blank_q, blank_d;
    logic                           fv_q, fv_d;
    logic                           code_err_q, code_err_d;
    logic                           sel_err_q, sel_err_d;

    logic [SW-1:0]                  sample_s;
    logic [NUM_DIGITS-1:0]          an_act_s;
    logic                           same_s;
    logic                           onehot_s;
    logic                           multi_s;
    logic                           capture_s;
    logic                           sel_hit_s;
    logic                           frame_done_s;
    logic [5:0]                     dec_s;

    // Next-state logic: stability counters, capture, frame assembly, sticky errors.
    always_comb begin
        sample_s     = {an_s2_q, seg_s2_q};
        an_act_s     = ~an_s2_q;
        same_s       = (sample_s == prev_q);
        onehot_s     = is_onehot(an_act_s);
        multi_s      = (an_act_s != AN_ZERO) && !onehot_s;
        dec_s        = seg_decode(~seg_s2_q);
        frame_done_s = &seen_q;

        hot_cnt_d    = CNT_ZERO;
        multi_cnt_d  = CNT_ZERO;
        seen_d       = seen_q;
        dig_nib_d    = dig_nib_q;
        dig_blank_d  = dig_blank_q;
        value_d      = value_q;
        blank_d      = blank_q;
        fv_d         = 1'b0;
        code_err_d   = code_err_q;
        sel_err_d    = sel_err_q;

        // One-hot path: count identical samples, saturating at CNT_MAX.
        if (same_s && onehot_s) begin
            if (hot_cnt_q == CNT_MAX) begin
                hot_cnt_d = CNT_MAX;
            end else begin
                hot_cnt_d = hot_cnt_q + CNT_ONE;
            end
        end else if (onehot_s) begin
            hot_cnt_d = CNT_ONE;
        end else begin
            hot_cnt_d = CNT_ZERO;
        end

        // Multi-hot path uses the same rule but only raises sel_err.
        if (same_s && multi_s) begin
            if (multi_cnt_q == CNT_MAX) begin
                multi_cnt_d = CNT_MAX;
            end else begin
                multi_cnt_d = multi_cnt_q + CNT_ONE;
            end
        end else if (multi_s) begin
            multi_cnt_d = CNT_ONE;
        end else begin
            multi_cnt_d = CNT_ZERO;
        end

        // Only the PRE->MAX step captures, so a saturated counter never recaptures.
        capture_s = same_s && onehot_s && (hot_cnt_q == CNT_PRE);
        sel_hit_s = same_s && multi_s && (multi_cnt_q == CNT_PRE);

        // Publish the frame; clear the mask first so a same-cycle capture survives.
        if (frame_done_s) begin
            value_d = dig_nib_q;
            blank_d = dig_blank_q;
            fv_d    = 1'b1;
            seen_d  = AN_ZERO;
        end else begin
            value_d = value_q;
            blank_d = blank_q;
        end

        if (capture_s) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (an_act_s[i]) begin
                    dig_nib_d[i]   = dec_s[3:0];
                    dig_blank_d[i] = dec_s[4];
                end else begin
                    dig_nib_d[i]   = dig_nib_q[i];
                    dig_blank_d[i] = dig_blank_q[i];
                end
            end
            seen_d = seen_d | an_act_s;
        end else begin
            seen_d = seen_d;
        end

        // A new error event beats a coincident clear.
        if (capture_s && !dec_s[5]) begin
            code_err_d = 1'b1;
        end else if (err_clr_i) begin
            code_err_d = 1'b0;
        end else begin
            code_err_d = code_err_q;
        end

        if (sel_hit_s) begin
            sel_err_d = 1'b1;
        end else if (err_clr_i) begin
            sel_err_d = 1'b0;
        end else begin
            sel_err_d = sel_err_q;
        end
    end

    // State registers, including the 2-flop input synchronizers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q    <= 7'h00;
            seg_s2_q    <= 7'h00;
            an_s1_q     <= AN_ZERO;
            an_s2_q     <= AN_ZERO;
            prev_q      <= {SW{1'b0}};
            hot_cnt_q   <= CNT_ZERO;
            multi_cnt_q <= CNT_ZERO;
            seen_q      <= AN_ZERO;
            dig_nib_q   <= {(4*NUM_DIGITS){1'b0}};
            dig_blank_q <= AN_ZERO;
            value_q     <= {(4*NUM_DIGITS){1'b0}};
            blank_q     <= AN_ZERO;
            fv_q        <= 1'b0;
            code_err_q  <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            seg_s1_q    <= seg_n_i;
            seg_s2_q    <= seg_s1_q;
            an_s1_q     <= an_n_i;
            an_s2_q     <= an_s1_q;
            prev_q      <= sample_s;
            hot_cnt_q   <= hot_cnt_d;
            multi_cnt_q <= multi_cnt_d;
            seen_q      <= seen_d;
            dig_nib_q   <= dig_nib_d;
            dig_blank_q <= dig_blank_d;
            value_q     <= value_d;
            blank_q     <= blank_d;
            fv_q        <= fv_d;
            code_err_q  <= code_err_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign value_o       = value_q;
    assign blank_mask_o  = blank_q;
    assign frame_valid_o = fv_q;
    assign code_err_o    = code_err_q;
    assign sel_err_o     = sel_err_q;

endmodule

// File: tb/tb_seg7_display_snoop.sv
// -----------------------------------------------------------------------------
// tb_seg7_display_snoop
//
// Directed bench for seg7_display_snoop with NUM_DIGITS=4, STABLE_CYCLES=4.
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge.
//
// A small monitor counts frame_valid cycles and latches value/blank_mask
// whenever frame_valid is seen high.
// -----------------------------------------------------------------------------
module tb_seg7_display_snoop;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  an_n = 4'hF;
    logic        err_clr = 1'b0;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic        frame_valid;
    logic        code_err;
    logic        sel_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fv_count = 0;
    int fv_cyc = 0;
    int fv_base = 0;
    int last_start = 0;
    logic [15:0] last_value = 16'h0;
    logic [3:0]  last_blank = 4'h0;

    seg7_display_snoop #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seg_n_i       (seg_n),
        .an_n_i        (an_n),
        .err_clr_i     (err_clr),
        .value_o       (value),
        .blank_mask_o  (blank_mask),
        .frame_valid_o (frame_valid),
        .code_err_o    (code_err),
        .sel_err_o     (sel_err)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Count rising edges so latency can be measured.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every frame_valid cycle and the values published with it.
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_count   = fv_count + 1;
            last_value = value;
            last_blank = blank_mask;
            fv_cyc     = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Show an active-high pattern on one digit, then a 2-cycle blanking gap.
    task automatic show(input int d, input logic [6:0] pat, input int hold);
        logic [3:0] one;
        one = 4'b0001;
        an_n = ~(one << d);
        seg_n = ~pat;
        last_start = cyc;
        repeat (hold) @(negedge clk);
        an_n = 4'hF;
        seg_n = 7'h7F;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("rst_value", value, 16'h0000);
        check_eq("rst_blank", blank_mask, 4'h0);
        check_eq("rst_fv", frame_valid, 1'b0);
        check_eq("rst_code_err", code_err, 1'b0);
        check_eq("rst_sel_err", sel_err, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic sweep 1,2,3,4.
        fv_base = fv_count;
        show(0, 7'h06, 8);
        show(1, 7'h5B, 8);
        show(2, 7'h4F, 8);
        show(3, 7'h66, 8);
        check_eq("sweep_fv_cnt", fv_count - fv_base, 1);
        check_eq("sweep_value", last_value, 16'h4321);
        check_eq("sweep_blank", last_blank, 4'h0);
        check_eq("sweep_out_value", value, 16'h4321);
        check_eq("sweep_code_err", code_err, 1'b0);
        check_eq("sweep_sel_err", sel_err, 1'b0);
        // First pin edge k+1, capture edge k+6, frame_valid after edge k+7.
        check_eq("sweep_latency", fv_cyc - last_start, 7);

        // Digit2 held 3 cycles: shorter than the stability window, so it is not captured.
        fv_base = fv_count;
        show(0, 7'h06, 8);
        show(1, 7'h5B, 8);
        show(2, 7'h4F, 3);
        show(3, 7'h66, 8);
        check_eq("short_no_fv", fv_count - fv_base, 0);
        // Next sweep completes the mask at digit2; digit3 still holds 4.
        show(0, 7'h6D, 8);
        show(1, 7'h7D, 8);
        show(2, 7'h07, 8);
        show(3, 7'h7F, 8);
        check_eq("short_fv_cnt", fv_count - fv_base, 1);
        check_eq("short_value", last_value, 16'h4765);

        // Blank digit1, others A, b, C.
        do_reset();
        fv_base = fv_count;
        show(0, 7'h77, 8);
        show(1, 7'h00, 8);
        show(2, 7'h7C, 8);
        show(3, 7'h39, 8);
        check_eq("blank_fv_cnt", fv_count - fv_base, 1);
        check_eq("blank_value", last_value, 16'hCB0A);
        check_eq("blank_mask", last_blank, 4'b0010);
        check_eq("blank_code_err", code_err, 1'b0);

        // Invalid pattern on digit3.
        do_reset();
        show(3, 7'h49, 8);
        check_eq("inv_code_err", code_err, 1'b1);
        pulse_clr();
        check_eq("inv_clr", code_err, 1'b0);
        // err_clr on the capture edge: the new error wins.
        an_n = 4'b0111;
        seg_n = ~7'h49;
        repeat (5) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("inv_clr_vs_set", code_err, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("inv_sticky", code_err, 1'b1);
        an_n = 4'hF;
        seg_n = 7'h7F;
        repeat (2) @(negedge clk);

        // Multi-hot anodes: sel_err, no capture.
        do_reset();
        fv_base = fv_count;
        show(0, 7'h06, 8);
        show(1, 7'h5B, 8);
        show(2, 7'h4F, 8);
        an_n = 4'b1100;
        seg_n = ~7'h7D;
        repeat (10) @(negedge clk);
        an_n = 4'hF;
        seg_n = 7'h7F;
        repeat (2) @(negedge clk);
        check_eq("sel_err_set", sel_err, 1'b1);
        check_eq("sel_no_fv", fv_count - fv_base, 0);
        show(3, 7'h66, 8);
        check_eq("sel_fv_cnt", fv_count - fv_base, 1);
        check_eq("sel_value", last_value, 16'h4321);
        pulse_clr();
        check_eq("sel_clr", sel_err, 1'b0);

        // Reset in the middle of a frame.
        show(0, 7'h6F, 8);
        show(1, 7'h77, 8);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_value", value, 16'h0000);
        check_eq("midrst_fv", frame_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fv_base = fv_count;
        show(2, 7'h6D, 8);
        show(3, 7'h7D, 8);
        check_eq("midrst_no_fv", fv_count - fv_base, 0);
        show(0, 7'h07, 8);
        show(1, 7'h7F, 8);
        check_eq("midrst_fv_cnt", fv_count - fv_base, 1);
        check_eq("midrst_value_new", last_value, 16'h6587);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
